// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle W-bit add/sub, one nibble per clock
//
// four_bit_full_adder: combinational 4-bit ripple adder.
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
//
// nibble_serial_adder: captures W = 4*NIBBLES bit operands, pushes them through
// a single four_bit_full_adder LSB nibble first, and presents the result on a
// valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand request handshake
//   in_a, in_b          : operands
//   in_cin              : carry in (ignored when in_sub=1)
//   in_sub              : 1 = A - B
//   out_valid/out_ready : result handshake
//   out_sum             : W-bit result
//   out_cout            : carry out of MSB nibble (subtract: 1 = no borrow)
//   out_ovf             : signed overflow

module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic c;

    always_comb begin
        c   = cin;
        sum = 4'd0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_sum_q, out_sum_d;
    logic            out_cout_q, out_cout_d;
    logic            out_ovf_q, out_ovf_d;

    logic [3:0] nib_a, nib_b, nib_sum;
    logic       nib_cout;

    assign nib_a = op_a_q[4*idx_q +: 4];
    assign nib_b = op_b_q[4*idx_q +: 4];

    four_bit_full_adder u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        acc_d      = acc_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the inversion and forced
                    // carry happen once at capture time.
                    op_a_d  = in_a;
                    op_b_d  = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[4*idx_q +: 4] = nib_sum;
                carry_d             = nib_cout;
                if (idx_q == LAST_IDX) begin
                    // Result is published only here so partial sums never
                    // appear on out_sum.
                    state_d    = S_DONE;
                    out_sum_d  = acc_d;
                    out_cout_d = nib_cout;
                    out_ovf_d  = (op_a_q[W-1] == op_b_q[W-1]) &&
                                 (nib_sum[3] != op_a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            acc_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            acc_q      <= acc_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    logic         i1_valid = 1'b0;
    logic         i1_ready;
    logic [3:0]   i1_a = '0;
    logic [3:0]   i1_b = '0;
    logic         i1_cin = 1'b0;
    logic         i1_sub = 1'b0;
    logic         o1_valid;
    logic         o1_ready = 1'b1;
    logic [3:0]   o1_sum;
    logic         o1_cout;
    logic         o1_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit busy     = 0;
    bit rand_or  = 0;
    logic [W+1:0] exp_q[$];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i1_valid), .in_ready(i1_ready),
        .in_a(i1_a), .in_b(i1_b), .in_cin(i1_cin), .in_sub(i1_sub),
        .out_valid(o1_valid), .out_ready(o1_ready),
        .out_sum(o1_sum), .out_cout(o1_cout), .out_ovf(o1_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference: plain integer arithmetic, packed as {cout, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b,
                                           input logic cin, sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: timing of in_ready/out_valid and result values.
    always @(negedge clk) begin
        bit ev;
        if (!rst_n) begin
            exp_q.delete();
            busy = 0;
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end else begin
            ev = busy && ((cyc - acc_cyc) >= N);
            chk("in_ready", 64'(in_ready), 64'(!busy));
            chk("out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                if (exp_q.size() == 0) chk("result_no_model", 64'd1, 64'd0);
                else chk("result", 64'({out_cout, out_ovf, out_sum}), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    busy = 0;
                end
            end else if (!busy && in_valid) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                busy    = 1;
                acc_cyc = cyc + 1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic do_op(input logic [W-1:0] a, b, input logic cin, sub);
        int t;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
        end
        if (t >= 200) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        #2;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_sum", 64'(out_sum), 64'd0);
        chk("reset_cout_ovf", 64'({out_cout, out_ovf}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed values pin the reference model.
        chk("model_basic", 64'(model(16'h1234, 16'h0FFF, 0, 0)), 64'({2'b00, 16'h2233}));
        chk("model_ripple", 64'(model(16'hFFFF, 16'h0001, 0, 0)), 64'({2'b10, 16'h0000}));
        chk("model_ovf", 64'(model(16'h7FFF, 16'h0001, 0, 0)), 64'({2'b01, 16'h8000}));
        chk("model_sub", 64'(model(16'h0005, 16'h0007, 1, 1)), 64'({2'b00, 16'hFFFE}));
        chk("model_sub_ovf", 64'(model(16'h8000, 16'h0001, 0, 1)), 64'({2'b11, 16'h7FFF}));

        // NIBBLES=1 instance: registered 4-bit add, valid one cycle after accept.
        i1_a = 4'h9; i1_b = 4'h8; i1_cin = 1'b1; i1_valid = 1'b1;
        @(posedge clk); #1 i1_valid = 1'b0;
        @(negedge clk);
        chk("n1_not_yet_valid", 64'(o1_valid), 64'd0);
        @(negedge clk);
        chk("n1_valid", 64'(o1_valid), 64'd1);
        chk("n1_result", 64'({o1_cout, o1_ovf, o1_sum}), 64'({2'b11, 4'h2}));
        @(negedge clk);
        chk("n1_valid_drop", 64'(o1_valid), 64'd0);
        chk("n1_ready_back", 64'(i1_ready), 64'd1);
        @(posedge clk); #1;

        // Directed operations.
        do_op(16'h1234, 16'h0FFF, 0, 0); wait_idle();
        do_op(16'hFFFF, 16'h0001, 0, 0); wait_idle();
        do_op(16'h7FFF, 16'h0001, 0, 0); wait_idle();
        do_op(16'h0005, 16'h0007, 1, 1); wait_idle();
        do_op(16'h8000, 16'h0001, 0, 1); wait_idle();

        // Backpressure with a competing request held during DONE.
        out_ready = 1'b0;
        do_op(16'hA5A5, 16'h5A5B, 1, 0);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (out_valid) break;
            t++;
        end
        if (t >= 50) chk("bp_valid_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_a = 16'h1111; in_b = 16'h0F0F; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        do_op(16'h1111, 16'h0F0F, 0, 1);
        wait_idle();

        // Randomized operations with random gaps and random out_ready.
        rand_or = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            if ($time % 10 != 6) begin @(posedge clk); #1; end
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_or = 0;
        #0 out_ready = 1'b1;
        wait_idle();

        // Reset while idx == 2: outputs clear asynchronously.
        do_op(16'h1357, 16'h2468, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_sum", 64'(out_sum), 64'd0);
        chk("async_cout_ovf", 64'({out_cout, out_ovf}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_op(16'h0F0F, 16'h00F1, 1, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
